// File: rtl/sound_sequencer.sv
// Note sequencer: queues {note,duration} words and plays them as tone-load / start / stop events.
// Outputs are registered; a write to a full FIFO is dropped unless a pop happens in the same cycle.
module sound_sequencer #(
  parameter int TICK_DIV   = 100000,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        flush,
  output logic        data_tx,
  output logic [8:0]  data,
  output logic        enable,
  output logic        busy,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, START, PLAY, STOP, GAP} state_t;

  state_t        state;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [15:0]   head;
  logic          pop, push, drop;
  logic [7:0]    dur_r;
  logic [PW-1:0] pre;
  logic [7:0]    tick;
  logic [7:0]    gap_cnt;
  logic          play_end, go_stop;

  assign head = mem[rd_ptr];
  assign pop  = (state == IDLE) && (count != '0) && !flush;
  assign push = wr_en && !flush && ((count != DEPTH_C) || pop);
  assign drop = wr_en && !flush && (count == DEPTH_C) && !pop;

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (push && !pop)
      count_nxt = count + CW'(1);
    else if (pop && !push)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      count      <= count_nxt;
      fifo_full  <= (count_nxt == DEPTH_C);
      fifo_empty <= (count_nxt == '0);
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (drop) overflow <= 1'b1;
      end
    end
  end

  // Last PLAY cycle: final prescaler count of the final tick.
  assign play_end = (state == PLAY) && (pre == PRE_LAST) && (tick == dur_r - 8'd1);
  assign go_stop  = ((state == LOAD || state == START || state == PLAY) && flush) || play_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      data_tx <= 1'b0;
      data    <= '0;
      enable  <= 1'b0;
      busy    <= 1'b0;
      dur_r   <= '0;
      pre     <= '0;
      tick    <= '0;
      gap_cnt <= '0;
    end else begin
      data_tx <= 1'b0;
      if (go_stop) begin
        state   <= STOP;
        data_tx <= 1'b1;
        data    <= '0;
        enable  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (pop) begin
              dur_r <= head[7:0];
              pre   <= '0;
              tick  <= '0;
              // Zero-duration entries are consumed silently; note 0 is a rest.
              if (head[7:0] != 8'd0) begin
                busy <= 1'b1;
                if (head[15:8] == 8'd0) begin
                  state <= PLAY;
                end else begin
                  state   <= LOAD;
                  data_tx <= 1'b1;
                  data    <= {1'b1, head[15:8]};
                end
              end
            end
          end
          LOAD: begin
            state  <= START;
            enable <= 1'b1;
          end
          START: begin
            state <= PLAY;
            pre   <= '0;
            tick  <= '0;
          end
          PLAY: begin
            if (pre == PRE_LAST) begin
              pre  <= '0;
              tick <= tick + 8'd1;
            end else begin
              pre <= pre + PW'(1);
            end
          end
          STOP: begin
            state   <= GAP;
            gap_cnt <= '0;
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
